mem_port_arbiter: RTL and testbench

- Shares one backing-memory port between the instruction-cache and data-cache refill/write paths.
- Each cache side uses the existing valid / addr / write_enabled / w_data / r_data / status handshake, with the same 2-bit status encoding as the data cache.
- Round-robin grant on conflict, one outstanding transaction at a time.
- Per-transaction ack timeout; a timeout produces an error status instead of hanging the pipeline.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one backing-memory port between the I-cache and D-cache.
// It allows one outstanding transaction at a time and aborts a transaction when the memory ack times out.
module mem_port_arbiter #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_write_enabled,
    input  logic [DATA_W-1:0] i_w_data,
    output logic [DATA_W-1:0] i_r_data,
    output logic [1:0]        i_status,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_write_enabled,
    input  logic [DATA_W-1:0] d_w_data,
    output logic [DATA_W-1:0] d_r_data,
    output logic [1:0]        d_status,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_d
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP_OK, RESP_ERR} state_t;

    state_t             state, state_nxt;
    logic               last_d;
    logic               pick_d;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  lat_addr;
    logic               lat_we;
    logic [DATA_W-1:0]  lat_wdata;
    logic [1:0]         resp_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        // When both sides request, the grant goes to the side that did not win last time.
        pick_d    = d_valid && (!i_valid || !last_d);
        case (state)
            IDLE:     if (i_valid || d_valid) state_nxt = REQ;
            REQ: begin
                if (mem_ack)                                  state_nxt = RESP_OK;
                else if (TIMEOUT != 0 && cnt == CNT_LAST)     state_nxt = RESP_ERR;
            end
            RESP_OK,
            RESP_ERR: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_req   = (state == REQ);
        mem_we    = mem_req & lat_we;
        mem_addr  = mem_req ? lat_addr  : '0;
        mem_wdata = mem_req ? lat_wdata : '0;
        resp_code = (state == RESP_OK) ? 2'b10 : 2'b11;
        i_status  = '0;
        d_status  = '0;
        // Status is gated by reset so it drops together with the state register.
        if (rst) begin
            i_status = {1'b0, i_valid};
            d_status = {1'b0, d_valid};
            if (state == RESP_OK || state == RESP_ERR) begin
                if (grant_d) d_status = resp_code;
                else         i_status = resp_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d    <= 1'b1;
            grant_d   <= 1'b0;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            i_r_data  <= '0;
            d_r_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid || d_valid) begin
                        grant_d   <= pick_d;
                        lat_addr  <= pick_d ? d_addr          : i_addr;
                        lat_we    <= pick_d ? d_write_enabled : i_write_enabled;
                        lat_wdata <= pick_d ? d_w_data        : i_w_data;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        cnt <= '0;
                        if (!lat_we) begin
                            if (grant_d) d_r_data <= mem_rdata;
                            else         i_r_data <= mem_rdata;
                        end
                    end else if (state_nxt == RESP_ERR) begin
                        cnt <= '0;
                        if (grant_d) d_r_data <= '0;
                        else         i_r_data <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP_OK,
                RESP_ERR: last_d <= grant_d;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter.
// The bench compares the DUT against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;
    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        i_valid, d_valid, i_write_enabled, d_write_enabled;
    logic [31:0] i_addr, d_addr, i_w_data, d_w_data, i_r_data, d_r_data;
    logic [1:0]  i_status, d_status;
    logic        mem_req, mem_we, mem_ack, busy, grant_d;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        rq_v[2];
    logic [31:0] rq_a[2];
    logic        rq_we[2];
    logic [31:0] rq_wd[2];
    bit          pending[2];

    assign i_valid         = rq_v[0];
    assign i_addr          = rq_a[0];
    assign i_write_enabled = rq_we[0];
    assign i_w_data        = rq_wd[0];
    assign d_valid         = rq_v[1];
    assign d_addr          = rq_a[1];
    assign d_write_enabled = rq_we[1];
    assign d_w_data        = rq_wd[1];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_write_enabled(i_write_enabled),
        .i_w_data(i_w_data), .i_r_data(i_r_data), .i_status(i_status),
        .d_valid(d_valid), .d_addr(d_addr), .d_write_enabled(d_write_enabled),
        .d_w_data(d_w_data), .d_r_data(d_r_data), .d_status(d_status),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .grant_d(grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner of the in-flight transaction and how far it has progressed.
    int          m_owner;   // -1 none, 0 I side, 1 D side
    int          m_phase;   // 0 free, 1 memory access, 2 done pulse, 3 error pulse
    int          m_wait;
    int          ack_lat;
    bit          m_last_d, m_grant_d, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata[2];

    task automatic model_reset();
        m_owner = -1; m_phase = 0; m_wait = 0;
        m_last_d = 1'b1; m_grant_d = 1'b0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic model_step();
        int w;
        case (m_phase)
            0: if (rq_v[0] || rq_v[1]) begin
                if (rq_v[0] && rq_v[1]) w = m_last_d ? 0 : 1;
                else                    w = rq_v[1] ? 1 : 0;
                m_owner = w; m_grant_d = (w == 1);
                m_addr = rq_a[w]; m_we = rq_we[w]; m_wdata = rq_wd[w];
                m_wait = 0; m_phase = 1;
                ack_lat = ($urandom_range(0, 9) < 2) ? 1000 : int'($urandom_range(0, 3));
            end
            1: if (mem_ack) begin
                if (!m_we) m_rdata[m_owner] = mem_rdata;
                m_phase = 2;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_rdata[m_owner] = '0;
                    m_phase = 3;
                end
            end
            default: begin
                m_last_d = (m_owner == 1);
                pending[m_owner] = 1'b0;
                m_owner = -1;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_cycle();
        logic [1:0] es[2];
        for (int s = 0; s < 2; s++) begin
            es[s] = {1'b0, rq_v[s]};
            if (m_owner == s && m_phase >= 2) es[s] = (m_phase == 2) ? 2'b10 : 2'b11;
        end
        check_val("i_status", 64'(i_status), 64'(es[0]));
        check_val("d_status", 64'(d_status), 64'(es[1]));
        check_val("busy", 64'(busy), 64'(m_owner != -1));
        check_val("mem_req", 64'(mem_req), 64'(m_phase == 1));
        check_val("grant_d", 64'(grant_d), 64'(m_grant_d));
        check_val("i_r_data", 64'(i_r_data), 64'(m_rdata[0]));
        check_val("d_r_data", 64'(d_r_data), 64'(m_rdata[1]));
        if (m_phase == 1) begin
            check_val("mem_we", 64'(mem_we), 64'(m_we));
            check_val("mem_addr", 64'(mem_addr), 64'(m_addr));
            if (m_we) check_val("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mem_req"}, 64'(mem_req), 64'(0));
        check_val({tag, "_busy"}, 64'(busy), 64'(0));
        check_val({tag, "_i_status"}, 64'(i_status), 64'(0));
        check_val({tag, "_d_status"}, 64'(d_status), 64'(0));
        check_val({tag, "_grant_d"}, 64'(grant_d), 64'(0));
        check_val({tag, "_i_r_data"}, 64'(i_r_data), 64'(0));
        check_val({tag, "_d_r_data"}, 64'(d_r_data), 64'(0));
    endtask

    initial begin
        bit want_rst;
        int req_pct;
        rst = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int s = 0; s < 2; s++) begin
            rq_v[s] = 1'b0; rq_a[s] = '0; rq_we[s] = 1'b0; rq_wd[s] = '0; pending[s] = 1'b0;
        end
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        want_rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 400 == 200) want_rst = 1'b1;
            // Asynchronous reset in the middle of a memory access, released away from any edge.
            if (want_rst && m_phase == 1) begin
                want_rst = 1'b0;
                #2 rst = 1'b0;
                #1 check_reset_outputs("async_rst");
                @(posedge clk); #1;
                rst = 1'b1;
                model_reset();
                for (int s = 0; s < 2; s++) if (pending[s] && !rq_v[s]) pending[s] = 1'b0;
            end

            mem_rdata = $urandom;
            if (m_phase == 1) mem_ack = (m_wait == ack_lat);
            else              mem_ack = ($urandom_range(0, 3) == 0);

            req_pct = (cyc < 100) ? 100 : 50;
            for (int s = 0; s < 2; s++) begin
                if (pending[s]) begin
                    if (m_owner == s && m_phase == 1 && rq_v[s] && $urandom_range(0, 15) == 0)
                        rq_v[s] = 1'b0;
                end else if (int'($urandom_range(0, 99)) < req_pct) begin
                    pending[s] = 1'b1;
                    rq_v[s]  = 1'b1;
                    rq_a[s]  = $urandom;
                    rq_we[s] = (s == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                    rq_wd[s] = $urandom;
                end else begin
                    rq_v[s]  = 1'b0;
                    rq_a[s]  = $urandom;
                    rq_we[s] = ($urandom_range(0, 1) == 1);
                    rq_wd[s] = $urandom;
                end
            end

            @(negedge clk);
            check_cycle();
            model_step();
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
